// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM encoding, NOP constant and the
// per-cycle control bundle driven to the PC and pipeline registers.
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic npc_redirect;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  //                           pc  npc ifid idex exm mwb fif fid
  localparam ctrl_t CTRL_BOOT   = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
  localparam ctrl_t CTRL_RUN    = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam ctrl_t CTRL_REDIR  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
  localparam ctrl_t CTRL_LU     = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1};

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect requests into the controller and the resulting
// PC/pipeline-register controls plus performance counters.
interface pipe_ctrl_if;
  logic        lu_hazard;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        mem_busy;
  logic        pc_we;
  logic        npc_redirect;
  logic [31:0] redirect_pc;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output lu_hazard, ex_redirect, ex_target, mem_busy,
    input  pc_we, npc_redirect, redirect_pc, if_id_we, id_ex_we,
           ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  lu_hazard, ex_redirect, ex_target, mem_busy,
    output pc_we, npc_redirect, redirect_pc, if_id_we, id_ex_we,
           ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Two free-running 32-bit wrapping event counters (stall and flush).
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall_inc,
  input  logic        i_flush_inc,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: boot bubbles, load-use stalls, EX
// redirects and whole-pipe freeze on a busy memory, all Mealy outputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

  state_t      r_state, w_nstate;
  logic [3:0]  r_boot_cnt;
  logic        r_pend;
  logic [31:0] r_pend_pc;
  ctrl_t       w_ctrl;
  logic        w_stall_inc, w_flush_inc, w_latch, w_apply;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= BOOT_INIT;
      r_pend     <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      r_state <= w_nstate;
      if (r_state == ST_BOOT && r_boot_cnt != 4'd0) r_boot_cnt <= r_boot_cnt - 4'd1;
      if (w_latch) begin
        r_pend    <= 1'b1;
        r_pend_pc <= bus.ex_target;
      end else if (w_apply) begin
        r_pend    <= 1'b0;
      end
    end
  end

  // RUN and FREEZE share the unfrozen decode: FREEZE only differs by having
  // entered through a busy cycle, so a released freeze acts like RUN at once.
  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_nstate    = r_state;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_latch     = 1'b0;
    w_apply     = 1'b0;
    if (rst || r_state == ST_BOOT) begin
      w_ctrl = CTRL_BOOT;
      if (r_boot_cnt <= 4'd1) w_nstate = ST_RUN;
    end else if (bus.mem_busy) begin
      w_ctrl      = CTRL_FREEZE;
      w_stall_inc = 1'b1;
      w_latch     = bus.ex_redirect;
      w_nstate    = ST_FREEZE;
    end else begin
      w_nstate = ST_RUN;
      if (bus.ex_redirect || r_pend) begin
        w_ctrl      = CTRL_REDIR;
        w_flush_inc = 1'b1;
        w_apply     = 1'b1;
      end else if (bus.lu_hazard) begin
        w_ctrl      = CTRL_LU;
        w_stall_inc = 1'b1;
      end
    end
  end

  assign bus.pc_we        = w_ctrl.pc_we;
  assign bus.npc_redirect = w_ctrl.npc_redirect;
  assign bus.if_id_we     = w_ctrl.if_id_we;
  assign bus.id_ex_we     = w_ctrl.id_ex_we;
  assign bus.ex_mem_we    = w_ctrl.ex_mem_we;
  assign bus.mem_wb_we    = w_ctrl.mem_wb_we;
  assign bus.if_id_flush  = w_ctrl.if_id_flush;
  assign bus.id_ex_flush  = w_ctrl.id_ex_flush;
  assign bus.redirect_pc  = bus.ex_redirect ? bus.ex_target : r_pend_pc;

  pipe_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_stall_inc (w_stall_inc),
    .i_flush_inc (w_flush_inc),
    .o_stall_cnt (bus.stall_cnt),
    .o_flush_cnt (bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + random bench for pipe_ctrl against a cycle-level model of
// the control rules (boot window, busy freeze, pending redirect, load-use).
module tb_pipe_ctrl;
  localparam int BOOT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.BOOT_CYCLES(BOOT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          m_boot_left;
  bit          m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare mid-low-phase,
  // then advance the model to what the next rising edge will commit.
  task automatic step(input logic r, input logic busy, input logic redir,
                      input logic [31:0] tgt, input logic lu);
    logic [7:0]  exp_c;
    logic [7:0]  obs_c;
    logic [31:0] exp_pc;
    bit          inc_s, inc_f;
    @(negedge clk);
    rst = r;
    bus.mem_busy    = busy;
    bus.ex_redirect = redir;
    bus.ex_target   = tgt;
    bus.lu_hazard   = lu;
    #1;
    inc_s  = 0;
    inc_f  = 0;
    exp_pc = '0;
    // order: pc_we npc ifid_we idex_we exmem_we memwb_we ifid_fl idex_fl
    if (r || m_boot_left > 0)           exp_c = 8'b0011_1111;
    else if (busy) begin
      exp_c = 8'b0000_0000;
      inc_s = 1;
      if (redir) begin m_pend = 1; m_tgt = tgt; end
    end else if (redir || m_pend) begin
      exp_c  = 8'b1111_1111;
      exp_pc = redir ? tgt : m_tgt;
      inc_f  = 1;
      m_pend = 0;
    end else if (lu) begin
      exp_c = 8'b0001_1101;
      inc_s = 1;
    end else                            exp_c = 8'b1011_1100;

    obs_c = {bus.pc_we, bus.npc_redirect, bus.if_id_we, bus.id_ex_we,
             bus.ex_mem_we, bus.mem_wb_we, bus.if_id_flush, bus.id_ex_flush};
    check("ctrl", {24'd0, obs_c}, {24'd0, exp_c});
    if (exp_c[6]) check("redirect_pc", bus.redirect_pc, exp_pc);
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("flush_cnt", bus.flush_cnt, m_flush);

    if (r) begin
      m_boot_left = BOOT;
      m_pend  = 0;
      m_tgt   = '0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (m_boot_left > 0) m_boot_left--;
      if (inc_s) m_stall++;
      if (inc_f) m_flush++;
    end
  endtask

  initial begin
    bus.mem_busy    = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = '0;
    bus.lu_hazard   = 1'b0;
    m_boot_left = BOOT;
    m_pend  = 0;
    m_tgt   = '0;
    m_stall = '0;
    m_flush = '0;
    @(posedge clk);  // first reset edge gives the counters a known value

    // reset then boot window (redirect/hazard during boot must be ignored)
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'hdead_0000, 1);
    step(0, 1, 1, 32'hbeef_0000, 0);
    step(0, 0, 0, 32'h0, 0);
    check("boot_done_pc_we", {31'd0, bus.pc_we}, 32'd1);

    // load-use one cycle
    step(0, 0, 0, 32'h0, 1);
    check("lu_stall_cnt", bus.stall_cnt, 32'd0);
    step(0, 0, 0, 32'h0, 0);
    check("lu_stall_cnt_after", bus.stall_cnt, 32'd1);

    // redirect beats load-use
    step(0, 0, 1, 32'h0000_0040, 1);
    step(0, 0, 0, 32'h0, 0);
    check("redir_flush_cnt", bus.flush_cnt, 32'd1);
    check("redir_stall_kept", bus.stall_cnt, 32'd1);

    // busy 3 cycles, redirect in the 2nd, applied on the 4th
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 1, 32'h0000_0080, 0);
    step(0, 1, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    check("freeze_stall_cnt", bus.stall_cnt, 32'd4);

    // two pulses while frozen: last target wins, one flush
    step(0, 1, 1, 32'h0000_0100, 0);
    step(0, 1, 1, 32'h0000_0200, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    check("double_pulse_flush", bus.flush_cnt, 32'd3);

    // reset while frozen with a pending redirect: nothing ever emitted
    step(0, 1, 1, 32'h0000_0300, 0);
    step(1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0);
    check("post_rst_flush", bus.flush_cnt, 32'd0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom_range(79) == 0), ($urandom_range(3) == 0),
           ($urandom_range(6) == 0), $urandom, ($urandom_range(3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
